ltc2308_responder: RTL and testbench
====================================

Name: ltc2308_responder

Overview:
- Synthesizable slave-side model of the LTC2308 serial ADC, used to close the loop on our ADC initiator in simulation and on-board loopback without the physical converter.
- Oversamples CONVST/SCK/SDI on a fast system clock.
- Emulates conversion latency, captures the 6-bit config word, and shifts 12-bit channel data out MSB-first on SDO.
- Channel values come from a parallel input bus driven by the bench or by test registers.

Parameters:
- DATA_BITS, 12, result width per channel.
- T_CONV, 64, conversion time in clk cycles after a detected CONVST rise.
- SYNC_STAGES, 2, synchronizer depth on adc_convst/adc_sck/adc_sdi (min 2).

Ports:
- clk  in  1  system clock, must be ≥8× SCK frequency.
- reset_n  in  1  synchronous, active-low reset.
- ch_data  in  8*DATA_BITS  channel n value at bits [n*DATA_BITS +: DATA_BITS].
- adc_convst  in  1  convert start from initiator.
- adc_sck  in  1  serial clock from initiator.
- adc_sdi  in  1  config bits from initiator.
- adc_sdo  out  1  serial result to initiator.
- busy  out  1  high in CONVERT state.
- cfg_valid  out  1  one-clk pulse when a complete config word is captured.
- active_cfg  out  6  config word applied to the next conversion.
- frame_cnt  out  16  completed 12-bit frames, wraps at 0xFFFF→0.
- proto_err  out  1  sticky protocol-violation flag.
- err_clr  in  1  clears proto_err; has priority over a same-cycle set.

Behaviour:
- Reset values: adc_sdo=0, busy=0, cfg_valid=0, active_cfg=6'b100010 (single-ended, CH0, unipolar, no sleep), frame_cnt=0, proto_err=0, state IDLE, synchronizers cleared.
- Inputs pass through SYNC_STAGES flops plus one edge-detect register. Edge events are therefore seen SYNC_STAGES+1 clk after the pin change.
- Config word format, MSB first: {S/D, O/S, S1, S0, UNI, SLP}.
- Channel decode: single-ended (S/D=1) → ch = {S1,S0,O/S}. Differential (S/D=0) → converted value 0. UNI and SLP are stored but ignored.
- State machine: IDLE, CONVERT, READY, SHIFT.
- Any state, CONVST rise:
  - latch conv_data = ch_data slice for active_cfg;
  - load conversion counter with T_CONV-1;
  - go to CONVERT, busy=1, adc_sdo=0.
  - If the previous state was SHIFT with bit_idx not yet complete, set proto_err.
- CONVERT: counter decrements each clk. At 0 → READY, busy=0, adc_sdo=conv_data[DATA_BITS-1]. An SCK edge in CONVERT sets proto_err and is ignored.
- READY: first SCK rise → SHIFT, rise count=1. If rise count ≤6, sample SDI into cfg_shift.
- SHIFT, SCK rise:
  - increment rise count;
  - sample SDI while count ≤6;
  - on the 6th rise, the next clk loads active_cfg with cfg_shift and pulses cfg_valid for 1 clk.
- SHIFT, SCK fall k (k=1..DATA_BITS-1): adc_sdo=conv_data[DATA_BITS-1-k], updated 1 clk after the fall event.
- SHIFT, SCK fall k=DATA_BITS: adc_sdo=0, frame_cnt+1, → IDLE.
- Extra SCK edges in IDLE are ignored. SDO stays 0 and there is no error.
- A frame aborted before the 6th rise leaves active_cfg unchanged.
- ch_data is sampled only at the CONVST rise. Later changes do not affect the current frame.
- Pipelining: the config shifted in during frame N selects the channel for conversion N+1, matching the real device.
- Reset asserted mid-frame: return to reset values on the next clk, and discard the partially captured config.
- Simultaneous CONVST rise and SCK edge in the same clk: CONVST wins, the SCK edge is dropped, and the proto_err rules above apply.

Test Plan:
- After reset, ch_data CH0=0xABC, one full frame with SDI=6'b110010 → SDO bits 1010_1011_1100. active_cfg becomes 110010 and cfg_valid pulses once. frame_cnt=1.
- Second frame with CH1=0x123 → SDO shifts 0x123. This confirms the one-frame config pipeline.
- Sweep all 8 single-ended configs (addresses 000,100,001,101,010,110,011,111), each channel loaded with 0x800|n → each following frame returns the matching value. Differential config 0xxxxx → next frame returns 0x000.
- SCK toggled 3 clk after CONVST with T_CONV=64 → proto_err=1 and SDO=0 throughout CONVERT. err_clr pulse → proto_err=0.
- CONVST re-asserted after only 4 SCK rises → proto_err=1, active_cfg unchanged, new conversion starts, frame_cnt not incremented.
- reset_n low for 1 clk mid-SHIFT at bit 7 → all outputs at reset values next clk. The following clean frame returns CH0 data.

Source files
------------

// File: rtl/ltc2308_responder.sv
// Slave-side LTC2308 emulator: oversamples CONVST/SCK/SDI, models conversion latency,
// captures the 6-bit config word and shifts channel data out MSB-first on SDO.
module ltc2308_responder #(
  parameter int unsigned DATA_BITS   = 12,
  parameter int unsigned T_CONV      = 64,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [8*DATA_BITS-1:0] ch_data,
  input  logic                   adc_convst,
  input  logic                   adc_sck,
  input  logic                   adc_sdi,
  output logic                   adc_sdo,
  output logic                   busy,
  output logic                   cfg_valid,
  output logic [5:0]             active_cfg,
  output logic [15:0]            frame_cnt,
  output logic                   proto_err,
  input  logic                   err_clr
);

  localparam int unsigned CNT_W     = $clog2(T_CONV + 1);
  localparam int unsigned BIT_W     = $clog2(DATA_BITS + 1);
  localparam int unsigned CFG_BITS  = 6;
  localparam logic [5:0]  CFG_RESET = 6'b100010;

  typedef enum logic [1:0] {IDLE, CONVERT, READY, SHIFT} state_t;

  state_t                 state, state_d;
  logic [SYNC_STAGES-1:0] convst_sync, sck_sync, sdi_sync;
  logic                   convst_prev, sck_prev;
  logic                   convst_rise, sck_rise, sck_fall, sdi_s;

  logic [DATA_BITS-1:0]   conv_data, conv_data_d, sel_data, conv_shifted;
  logic [CNT_W-1:0]       conv_cnt, conv_cnt_d;
  logic [BIT_W-1:0]       rise_cnt, rise_cnt_d, fall_cnt, fall_cnt_d;
  logic [CFG_BITS-1:0]    cfg_shift, cfg_shift_d;
  logic                   cfg_pend, cfg_pend_d;
  logic [2:0]             ch_sel;

  logic                   adc_sdo_d, busy_d, cfg_valid_d, proto_err_d, err_set;
  logic [5:0]             active_cfg_d;
  logic [15:0]            frame_cnt_d;

  // Pin synchronizers plus edge-detect history
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      convst_sync <= '0;
      sck_sync    <= '0;
      sdi_sync    <= '0;
      convst_prev <= 1'b0;
      sck_prev    <= 1'b0;
    end else begin
      convst_sync <= {convst_sync[SYNC_STAGES-2:0], adc_convst};
      sck_sync    <= {sck_sync[SYNC_STAGES-2:0], adc_sck};
      sdi_sync    <= {sdi_sync[SYNC_STAGES-2:0], adc_sdi};
      convst_prev <= convst_sync[SYNC_STAGES-1];
      sck_prev    <= sck_sync[SYNC_STAGES-1];
    end
  end

  assign convst_rise = convst_sync[SYNC_STAGES-1] & ~convst_prev;
  assign sck_rise    = sck_sync[SYNC_STAGES-1] & ~sck_prev;
  assign sck_fall    = ~sck_sync[SYNC_STAGES-1] & sck_prev;
  assign sdi_s       = sdi_sync[SYNC_STAGES-1];

  // Single-ended address {O/S,S1,S0} maps to channel {S1,S0,O/S}
  assign ch_sel   = {active_cfg[3], active_cfg[2], active_cfg[4]};
  assign sel_data = active_cfg[5] ? ch_data[32'(ch_sel)*DATA_BITS +: DATA_BITS] : '0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      conv_data  <= '0;
      conv_cnt   <= '0;
      rise_cnt   <= '0;
      fall_cnt   <= '0;
      cfg_shift  <= '0;
      cfg_pend   <= 1'b0;
      adc_sdo    <= 1'b0;
      busy       <= 1'b0;
      cfg_valid  <= 1'b0;
      active_cfg <= CFG_RESET;
      frame_cnt  <= '0;
      proto_err  <= 1'b0;
    end else begin
      state      <= state_d;
      conv_data  <= conv_data_d;
      conv_cnt   <= conv_cnt_d;
      rise_cnt   <= rise_cnt_d;
      fall_cnt   <= fall_cnt_d;
      cfg_shift  <= cfg_shift_d;
      cfg_pend   <= cfg_pend_d;
      adc_sdo    <= adc_sdo_d;
      busy       <= busy_d;
      cfg_valid  <= cfg_valid_d;
      active_cfg <= active_cfg_d;
      frame_cnt  <= frame_cnt_d;
      proto_err  <= proto_err_d;
    end
  end

  always_comb begin
    state_d      = state;
    conv_data_d  = conv_data;
    conv_cnt_d   = conv_cnt;
    rise_cnt_d   = rise_cnt;
    fall_cnt_d   = fall_cnt;
    cfg_shift_d  = cfg_shift;
    cfg_pend_d   = 1'b0;
    adc_sdo_d    = adc_sdo;
    cfg_valid_d  = 1'b0;
    active_cfg_d = active_cfg;
    frame_cnt_d  = frame_cnt;
    err_set      = 1'b0;
    conv_shifted = conv_data << (fall_cnt + BIT_W'(1));

    // Config word captured on the 6th rise commits one clk later
    if (cfg_pend) begin
      active_cfg_d = cfg_shift;
      cfg_valid_d  = 1'b1;
    end

    // CONVST rise preempts everything, including a same-cycle SCK edge
    if (convst_rise) begin
      conv_data_d = sel_data;
      conv_cnt_d  = CNT_W'(T_CONV - 1);
      rise_cnt_d  = '0;
      fall_cnt_d  = '0;
      cfg_shift_d = '0;
      adc_sdo_d   = 1'b0;
      state_d     = CONVERT;
      if (state == SHIFT) err_set = 1'b1;
    end else begin
      case (state)
        CONVERT: begin
          if (sck_rise || sck_fall) err_set = 1'b1;
          if (conv_cnt == '0) begin
            state_d   = READY;
            adc_sdo_d = conv_data[DATA_BITS-1];
          end else begin
            conv_cnt_d = conv_cnt - CNT_W'(1);
          end
        end
        READY: begin
          if (sck_rise) begin
            state_d     = SHIFT;
            rise_cnt_d  = BIT_W'(1);
            cfg_shift_d = {cfg_shift[CFG_BITS-2:0], sdi_s};
          end
        end
        SHIFT: begin
          if (sck_rise) begin
            if (rise_cnt != '1) rise_cnt_d = rise_cnt + BIT_W'(1);
            if (rise_cnt < BIT_W'(CFG_BITS)) begin
              cfg_shift_d = {cfg_shift[CFG_BITS-2:0], sdi_s};
              if (rise_cnt == BIT_W'(CFG_BITS - 1)) cfg_pend_d = 1'b1;
            end
          end
          if (sck_fall) begin
            fall_cnt_d = fall_cnt + BIT_W'(1);
            if (fall_cnt == BIT_W'(DATA_BITS - 1)) begin
              adc_sdo_d   = 1'b0;
              frame_cnt_d = frame_cnt + 16'd1;
              state_d     = IDLE;
            end else begin
              adc_sdo_d = conv_shifted[DATA_BITS-1];
            end
          end
        end
        default: ;
      endcase
    end

    busy_d      = (state_d == CONVERT);
    proto_err_d = err_clr ? 1'b0 : (proto_err | err_set);
  end

endmodule

// File: tb/tb_ltc2308_responder.sv
// Bench for ltc2308_responder: acts as the ADC initiator and checks frames against a
// frame-level model of the converter (config pipeline, channel select, counters, error flag).
module tb_ltc2308_responder;

  localparam int unsigned DB     = 12;
  localparam int unsigned TC     = 64;
  localparam int unsigned HALF   = 8;

  logic          clk = 1'b0;
  logic          reset_n, adc_convst, adc_sck, adc_sdi, err_clr;
  logic [8*DB-1:0] ch_data;
  logic          adc_sdo, busy, cfg_valid, proto_err;
  logic [5:0]    active_cfg;
  logic [15:0]   frame_cnt;

  ltc2308_responder #(.DATA_BITS(DB), .T_CONV(TC), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .ch_data(ch_data), .adc_convst(adc_convst),
    .adc_sck(adc_sck), .adc_sdi(adc_sdi), .adc_sdo(adc_sdo), .busy(busy),
    .cfg_valid(cfg_valid), .active_cfg(active_cfg), .frame_cnt(frame_cnt),
    .proto_err(proto_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int cv_cnt = 0;
  always @(posedge clk) if (cfg_valid) cv_cnt <= cv_cnt + 1;

  int nvec = 0;
  int nmis = 0;

  logic [5:0]  m_cfg;
  logic [15:0] m_fcnt;
  logic        m_err;
  logic [11:0] m_data;

  typedef struct {
    logic [5:0]  cfg;
    logic [11:0] exp_next;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] model_sel(input logic [5:0] cfg, input logic [8*DB-1:0] d);
    int ch;
    if (!cfg[5]) return 12'h000;
    ch = (cfg[3] ? 4 : 0) + (cfg[2] ? 2 : 0) + (cfg[4] ? 1 : 0);
    return d[ch*DB +: DB];
  endfunction

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_conv();
    m_data = model_sel(m_cfg, ch_data);
    if (dut.state == 2'd3) m_err = 1'b1;
    adc_convst = 1'b1;
    clks(2);
    adc_convst = 1'b0;
    clks(3);
  endtask

  task automatic wait_ready(output int nz);
    int n = 0;
    nz = 0;
    while (busy && n < TC + 20) begin
      if (adc_sdo) nz++;
      clks(1);
      n++;
    end
    chk("ready_timeout", 32'(busy), 32'd0);
  endtask

  task automatic shift(input logic [5:0] cfg, input int nrise, output logic [11:0] got);
    got = '0;
    for (int i = 0; i < nrise; i++) begin
      adc_sdi = (i < 6) ? cfg[5-i] : 1'b0;
      clks(HALF);
      if (i < 12) got[11-i] = adc_sdo;
      adc_sck = 1'b1;
      clks(HALF);
      adc_sck = 1'b0;
    end
    adc_sdi = 1'b0;
    clks(HALF);
  endtask

  task automatic frame_chk(input logic [5:0] cfg, input string name, output logic [11:0] got);
    int nz;
    int cv0;
    start_conv();
    wait_ready(nz);
    cv0 = cv_cnt;
    shift(cfg, 12, got);
    m_cfg  = cfg;
    m_fcnt = m_fcnt + 16'd1;
    chk({name, "_data"}, 32'(got), 32'(m_data));
    chk({name, "_cfg"}, 32'(active_cfg), 32'(m_cfg));
    chk({name, "_fcnt"}, 32'(frame_cnt), 32'(m_fcnt));
    chk({name, "_cvalid"}, 32'(cv_cnt - cv0), 32'd1);
  endtask

  initial begin
    logic [11:0] got;
    logic [11:0] prev_exp;
    int nz, cv0;

    reset_n = 1'b0; adc_convst = 1'b0; adc_sck = 1'b0; adc_sdi = 1'b0; err_clr = 1'b0;
    ch_data = '0;
    m_cfg = 6'b100010; m_fcnt = '0; m_err = 1'b0;
    clks(3);
    reset_n = 1'b1;
    clks(2);

    chk("rst_sdo", 32'(adc_sdo), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cvalid", 32'(cfg_valid), 32'd0);
    chk("rst_cfg", 32'(active_cfg), 32'h22);
    chk("rst_fcnt", 32'(frame_cnt), 32'd0);
    chk("rst_err", 32'(proto_err), 32'd0);

    // First frame from CH0 while loading CH1 config
    ch_data[0*DB +: DB] = 12'hABC;
    ch_data[1*DB +: DB] = 12'h123;
    frame_chk(6'b110010, "f1", got);
    chk("f1_const", 32'(got), 32'hABC);
    chk("f1_cfgc", 32'(active_cfg), 32'h32);
    chk("f1_err", 32'(proto_err), 32'd0);
    frame_chk(6'b100010, "f2", got);
    chk("f2_const", 32'(got), 32'h123);

    // Channel sweep: each entry's config selects the following frame's data
    for (int n = 0; n < 8; n++) ch_data[n*DB +: DB] = 12'h800 | 12'(n);
    tbl[0] = '{6'b100010, 12'h800};
    tbl[1] = '{6'b110010, 12'h801};
    tbl[2] = '{6'b100110, 12'h802};
    tbl[3] = '{6'b110110, 12'h803};
    tbl[4] = '{6'b101010, 12'h804};
    tbl[5] = '{6'b111010, 12'h805};
    tbl[6] = '{6'b101110, 12'h806};
    tbl[7] = '{6'b111110, 12'h807};
    tbl[8] = '{6'b011010, 12'h000};
    prev_exp = 12'h800;
    for (int i = 0; i < 9; i++) begin
      frame_chk(tbl[i].cfg, "sweep", got);
      chk("sweep_tbl", 32'(got), 32'(prev_exp));
      prev_exp = tbl[i].exp_next;
    end
    frame_chk(6'b100010, "sweep_end", got);
    chk("sweep_end_tbl", 32'(got), 32'(prev_exp));

    // SCK toggled during conversion
    m_data = model_sel(m_cfg, ch_data);
    adc_convst = 1'b1; clks(2); adc_convst = 1'b0; clks(1);
    adc_sck = 1'b1; clks(2); adc_sck = 1'b0;
    wait_ready(nz);
    chk("conv_sdo_zero", 32'(nz), 32'd0);
    chk("conv_err_set", 32'(proto_err), 32'd1);
    err_clr = 1'b1; clks(1); err_clr = 1'b0; clks(1);
    chk("conv_err_clr", 32'(proto_err), 32'd0);
    cv0 = cv_cnt;
    shift(6'b100010, 12, got);
    m_fcnt = m_fcnt + 16'd1;
    chk("conv_frame_data", 32'(got), 32'(m_data));
    chk("conv_frame_fcnt", 32'(frame_cnt), 32'(m_fcnt));

    // Frame aborted after 4 rises
    start_conv();
    wait_ready(nz);
    cv0 = cv_cnt;
    shift(6'b101110, 4, got);
    start_conv();
    chk("abort_err", 32'(proto_err), 32'd1);
    chk("abort_busy", 32'(busy), 32'd1);
    chk("abort_cfg", 32'(active_cfg), 32'(m_cfg));
    chk("abort_fcnt", 32'(frame_cnt), 32'(m_fcnt));
    chk("abort_cvalid", 32'(cv_cnt - cv0), 32'd0);
    wait_ready(nz);
    shift(6'b100010, 12, got);
    m_fcnt = m_fcnt + 16'd1;
    chk("abort_next_data", 32'(got), 32'(m_data));
    err_clr = 1'b1; clks(1); err_clr = 1'b0;
    m_err = 1'b0;

    // Reset pulse mid-shift after 7 bits
    ch_data[0*DB +: DB] = 12'h5A3;
    start_conv();
    wait_ready(nz);
    shift(6'b111110, 7, got);
    chk("pre_rst_cfg", 32'(active_cfg), 32'h3E);
    reset_n = 1'b0; clks(1);
    chk("mrst_sdo", 32'(adc_sdo), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_cvalid", 32'(cfg_valid), 32'd0);
    chk("mrst_cfg", 32'(active_cfg), 32'h22);
    chk("mrst_fcnt", 32'(frame_cnt), 32'd0);
    chk("mrst_err", 32'(proto_err), 32'd0);
    reset_n = 1'b1; clks(2);
    m_cfg = 6'b100010; m_fcnt = '0; m_err = 1'b0;
    frame_chk(6'b100010, "post_rst", got);
    chk("post_rst_ch0", 32'(got), 32'h5A3);

    // Randomized frames; ch_data is disturbed after the CONVST rise
    for (int i = 0; i < 20; i++) begin
      logic [5:0] rc;
      rc = 6'($urandom_range(0, 63));
      ch_data = {$urandom, $urandom, $urandom};
      start_conv();
      ch_data = {$urandom, $urandom, $urandom};
      wait_ready(nz);
      cv0 = cv_cnt;
      shift(rc, 12, got);
      m_cfg  = rc;
      m_fcnt = m_fcnt + 16'd1;
      chk("rnd_data", 32'(got), 32'(m_data));
      chk("rnd_cfg", 32'(active_cfg), 32'(m_cfg));
      chk("rnd_fcnt", 32'(frame_cnt), 32'(m_fcnt));
      chk("rnd_cvalid", 32'(cv_cnt - cv0), 32'd1);
      chk("rnd_err", 32'(proto_err), 32'(m_err));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
